// File: rtl/fib_stream_gen.sv
// Additive-recurrence (Fibonacci-style) term generator with a valid/ready output stream.
// Define FIB_STREAM_GEN_SAT_EN to saturate terms at 2^W-1 instead of wrapping modulo 2^W.
module fib_stream_gen #(
  parameter int             W         = 8,
  parameter logic [W-1:0]   SEED0     = '0,
  parameter logic [W-1:0]   SEED1     = W'(1),
  parameter int             MAX_TERMS = 16
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic                                       load,
  input  logic [W-1:0]                               seed0_in,
  input  logic [W-1:0]                               seed1_in,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [W-1:0]                               out_data,
  output logic [((MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1)-1:0] term_idx,
  output logic                                       overflow,
  output logic                                       done
);

  // state  | meaning
  // S_IDLE | waiting for start or load, no term presented
  // S_RUN  | presenting term a at index idx
  // S_DONE | run complete, waiting for start or load
  localparam int IDX_W = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     state;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [IDX_W-1:0] idx;
  logic           ovf;
  logic [W:0]     sum;
  logic [W-1:0]   b_next;
  logic           hs;
  logic           last;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign hs   = (state == S_RUN) && out_ready;
  assign last = (idx == IDX_W'(MAX_TERMS - 1));

`ifdef FIB_STREAM_GEN_SAT_EN
  assign b_next = sum[W] ? {W{1'b1}} : sum[W-1:0];
`else
  assign b_next = sum[W-1:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      a     <= SEED0;
      b     <= SEED1;
      idx   <= '0;
      ovf   <= 1'b0;
    end else if (load) begin
      // load wins over start and over a same-cycle handshake
      state <= S_RUN;
      a     <= seed0_in;
      b     <= seed1_in;
      idx   <= '0;
      ovf   <= 1'b0;
    end else if (start && (state != S_RUN)) begin
      state <= S_RUN;
      a     <= SEED0;
      b     <= SEED1;
      idx   <= '0;
      ovf   <= 1'b0;
    end else if (hs) begin
      if (last) begin
        state <= S_DONE;
      end else begin
        a   <= b;
        b   <= b_next;
        idx <= idx + 1'b1;
        ovf <= ovf | sum[W];
      end
    end
  end

  assign out_valid = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign out_data  = a;
  assign term_idx  = idx;
  assign overflow  = ovf;

endmodule
